// File: rtl/if_spi_slave_if.sv
// rtl/if_spi_slave_if.sv - SPI pins plus TX/RX byte FIFO access for if_spi_slave
interface if_spi_slave_if #(
  parameter int RX_DEPTH = 128
);
  logic                        cs;
  logic                        sclk;
  logic                        mosi;
  logic                        miso;
  logic [7:0]                  in_data;
  logic                        in_ena;
  logic                        tx_full;
  logic                        rd_req;
  logic [7:0]                  out_data;
  logic                        have_msg;
  logic [$clog2(RX_DEPTH):0]   len;
  logic                        frame_err;
  logic                        tx_udf;
  logic                        rx_ovf;

  modport slave (
    input  cs, sclk, mosi, in_data, in_ena, rd_req,
    output miso, tx_full, out_data, have_msg, len, frame_err, tx_udf, rx_ovf
  );

  modport master (
    output cs, sclk, mosi, in_data, in_ena, rd_req,
    input  miso, tx_full, out_data, have_msg, len, frame_err, tx_udf, rx_ovf
  );
endinterface

// File: rtl/if_spi_slave.sv
// rtl/if_spi_slave.sv - oversampled SPI mode-0 slave with TX word FIFO and RX byte FIFO
module if_spi_slave #(
  parameter int D_WIDTH  = 16,
  parameter int TX_DEPTH = 256,
  parameter int RX_DEPTH = 128
) (
  input  logic           clk_i,
  input  logic           rst_i,
  if_spi_slave_if.slave  bus
);
  localparam int NB  = D_WIDTH / 8;
  localparam int TXA = $clog2(TX_DEPTH);
  localparam int TXC = TXA + 1;
  localparam int RXA = $clog2(RX_DEPTH);
  localparam int RXC = RXA + 1;
  localparam int WCW = $clog2(D_WIDTH);

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, ACTIVE} state_e;

  state_e              state_q, state_d;
  logic                cs_m_q, cs_s_q, sclk_m_q, sclk_s_q, sclk_d_q, mosi_m_q, mosi_s_q;
  logic [D_WIDTH-1:0]  shift_q, shift_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [WCW-1:0]      word_cnt_q, word_cnt_d;
  logic                load_pend_q, load_pend_d;
  logic                udf_pend_q, udf_pend_d;
  logic [7:0]          rx_sh_q, rx_sh_d;
  logic                rx_push_q, rx_push_d;
  logic                frame_err_q, frame_err_d;
  logic                tx_udf_q, tx_udf_d;
  logic [TXA-1:0]      tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
  logic [TXC-1:0]      tx_cnt_q, tx_cnt_d;
  logic [RXA-1:0]      rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
  logic [RXC-1:0]      rx_cnt_q, rx_cnt_d;
  logic                rx_ovf_q, rx_ovf_d;
  logic [7:0]          out_data_q, out_data_d;
  logic [7:0]          tx_mem [TX_DEPTH];
  logic [7:0]          rx_mem [RX_DEPTH];

  logic                rise, fall, enter, leave, stay;
  logic                tx_full, tx_have, tx_push, tx_pop, do_load;
  logic                rx_full, rx_wr, rx_rd;
  logic [D_WIDTH-1:0]  tx_word;

  assign rise    = sclk_s_q & ~sclk_d_q;
  assign fall    = ~sclk_s_q & sclk_d_q;
  assign stay    = (state_q == ACTIVE) && !cs_s_q;
  assign tx_full = (tx_cnt_q == TXC'(TX_DEPTH));
  assign tx_have = (tx_cnt_q >= TXC'(NB));
  assign tx_push = bus.in_ena & ~tx_full;
  assign do_load = enter | (stay & fall & load_pend_q);
  assign tx_pop  = do_load & tx_have;
  assign rx_full = (rx_cnt_q == RXC'(RX_DEPTH));
  assign rx_wr   = rx_push_q & ~rx_full;
  assign rx_rd   = bus.rd_req & (rx_cnt_q != '0);

  always_comb begin
    state_d = state_q;
    enter   = 1'b0;
    leave   = 1'b0;
    case (state_q)
      WAIT_IDLE: if (cs_s_q) state_d = IDLE;
      IDLE: if (!cs_s_q) begin
        state_d = ACTIVE;
        enter   = 1'b1;
      end
      ACTIVE: if (cs_s_q) begin
        state_d = IDLE;
        leave   = 1'b1;
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  // First byte popped lands in the top byte of the word.
  always_comb begin
    tx_word = '0;
    for (int k = 0; k < NB; k++) begin
      tx_word[D_WIDTH-1-8*k -: 8] = tx_mem[tx_rd_ptr_q + TXA'(k)];
    end
  end

  always_comb begin
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    word_cnt_d  = word_cnt_q;
    load_pend_d = load_pend_q;
    udf_pend_d  = udf_pend_q;
    rx_sh_d     = rx_sh_q;
    rx_push_d   = 1'b0;
    frame_err_d = 1'b0;
    tx_udf_d    = 1'b0;
    if (leave) begin
      shift_d     = '0;
      bit_cnt_d   = '0;
      word_cnt_d  = '0;
      load_pend_d = 1'b0;
      udf_pend_d  = 1'b0;
      frame_err_d = (bit_cnt_q != 3'd0);
    end else if (do_load) begin
      shift_d     = tx_have ? tx_word : '0;
      load_pend_d = 1'b0;
      udf_pend_d  = ~tx_have;
    end else if (stay && fall) begin
      shift_d = {shift_q[D_WIDTH-2:0], 1'b0};
    end
    // A starved load is only reported once the master clocks its first bit,
    // so the speculative load after a frame's final word never flags.
    if (stay && rise) begin
      rx_sh_d   = {rx_sh_q[6:0], mosi_s_q};
      bit_cnt_d = bit_cnt_q + 3'd1;
      rx_push_d = (bit_cnt_q == 3'd7);
      if (word_cnt_q == WCW'(D_WIDTH - 1)) begin
        word_cnt_d  = '0;
        load_pend_d = 1'b1;
      end else begin
        word_cnt_d = word_cnt_q + WCW'(1);
      end
      if (udf_pend_q) begin
        tx_udf_d   = 1'b1;
        udf_pend_d = 1'b0;
      end
    end
  end

  always_comb begin
    tx_wr_ptr_d = tx_push ? tx_wr_ptr_q + TXA'(1) : tx_wr_ptr_q;
    tx_rd_ptr_d = tx_pop ? tx_rd_ptr_q + TXA'(NB) : tx_rd_ptr_q;
    tx_cnt_d    = tx_cnt_q + TXC'(tx_push) - (tx_pop ? TXC'(NB) : TXC'(0));
    rx_wr_ptr_d = rx_wr ? rx_wr_ptr_q + RXA'(1) : rx_wr_ptr_q;
    rx_rd_ptr_d = rx_rd ? rx_rd_ptr_q + RXA'(1) : rx_rd_ptr_q;
    rx_cnt_d    = rx_cnt_q + RXC'(rx_wr) - RXC'(rx_rd);
    rx_ovf_d    = rx_ovf_q | (rx_push_q & rx_full);
    out_data_d  = rx_rd ? rx_mem[rx_rd_ptr_q] : out_data_q;
  end

  always_ff @(posedge clk_i) begin
    if (tx_push) tx_mem[tx_wr_ptr_q] <= bus.in_data;
    if (rx_wr)   rx_mem[rx_wr_ptr_q] <= rx_sh_q;
  end

  // Synchronisers clear to cs low so a frame in progress at reset is ignored.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      {cs_m_q, cs_s_q, sclk_m_q, sclk_s_q, sclk_d_q, mosi_m_q, mosi_s_q} <= '0;
      state_q     <= WAIT_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      word_cnt_q  <= '0;
      load_pend_q <= 1'b0;
      udf_pend_q  <= 1'b0;
      rx_sh_q     <= '0;
      rx_push_q   <= 1'b0;
      frame_err_q <= 1'b0;
      tx_udf_q    <= 1'b0;
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_cnt_q    <= '0;
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_cnt_q    <= '0;
      rx_ovf_q    <= 1'b0;
      out_data_q  <= '0;
    end else begin
      cs_m_q      <= bus.cs;
      cs_s_q      <= cs_m_q;
      sclk_m_q    <= bus.sclk;
      sclk_s_q    <= sclk_m_q;
      sclk_d_q    <= sclk_s_q;
      mosi_m_q    <= bus.mosi;
      mosi_s_q    <= mosi_m_q;
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      word_cnt_q  <= word_cnt_d;
      load_pend_q <= load_pend_d;
      udf_pend_q  <= udf_pend_d;
      rx_sh_q     <= rx_sh_d;
      rx_push_q   <= rx_push_d;
      frame_err_q <= frame_err_d;
      tx_udf_q    <= tx_udf_d;
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      tx_cnt_q    <= tx_cnt_d;
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_ovf_q    <= rx_ovf_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.miso      = (state_q == ACTIVE) & shift_q[D_WIDTH-1];
  assign bus.tx_full   = tx_full;
  assign bus.out_data  = out_data_q;
  assign bus.have_msg  = (rx_cnt_q != '0);
  assign bus.len       = rx_cnt_q;
  assign bus.frame_err = frame_err_q;
  assign bus.tx_udf    = tx_udf_q;
  assign bus.rx_ovf    = rx_ovf_q;
endmodule

// File: tb/tb_if_spi_slave.sv
// tb/tb_if_spi_slave.sv - directed bench for if_spi_slave acting as SPI master and packet host
module tb_if_spi_slave;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   udf_seen = 0;
  int   fe_seen = 0;
  logic [7:0] len_pre, len_post;

  if_spi_slave_if #(.RX_DEPTH(128)) bus();

  if_spi_slave dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.tx_udf)    udf_seen++;
      if (bus.frame_err) fe_seen++;
    end
  end

  typedef struct {
    logic [15:0] tx_word;
    logic [15:0] mosi_word;
    logic [15:0] exp_miso;
    logic [7:0]  exp_b0;
    logic [7:0]  exp_b1;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(6);
  endtask

  task automatic push_tx(input logic [7:0] b);
    bus.in_data = b;
    bus.in_ena  = 1'b1;
    tick(1);
    bus.in_ena  = 1'b0;
  endtask

  task automatic read_rx(output logic [7:0] b);
    bus.rd_req = 1'b1;
    tick(1);
    bus.rd_req = 1'b0;
    b = bus.out_data;
  endtask

  task automatic cs_begin();
    bus.cs = 1'b0;
    tick(8);
  endtask

  task automatic cs_end();
    tick(6);
    bus.cs = 1'b1;
    tick(8);
  endtask

  // Mode 0: mosi set while sclk low, miso captured just before each rise.
  // rd_bit selects a bit whose rise gets an rd_req aligned with the RX push.
  task automatic send_bits(input int n, input logic [31:0] mo, input int half,
                           input int rd_bit, output logic [31:0] mi);
    mi = '0;
    for (int i = 0; i < n; i++) begin
      bus.mosi = mo[n-1-i];
      tick(half);
      mi = {mi[30:0], bus.miso};
      bus.sclk = 1'b1;
      for (int h = 1; h <= half; h++) begin
        tick(1);
        bus.rd_req = (i == rd_bit) && (h == 3);
        if (i == rd_bit && h == 3) len_pre  = bus.len;
        if (i == rd_bit && h == 4) len_post = bus.len;
      end
      bus.rd_req = 1'b0;
      bus.sclk   = 1'b0;
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        vecs [4];
    logic [31:0] mi;
    logic [7:0]  b;
    int          u0, f0;

    vecs[0] = '{16'hA53C, 16'h1234, 16'hA53C, 8'h12, 8'h34};
    vecs[1] = '{16'hFFFF, 16'h0000, 16'hFFFF, 8'h00, 8'h00};
    vecs[2] = '{16'h0001, 16'h8000, 16'h0001, 8'h80, 8'h00};
    vecs[3] = '{16'h5AC3, 16'hFEDC, 16'h5AC3, 8'hFE, 8'hDC};

    bus.cs = 1'b1; bus.sclk = 1'b0; bus.mosi = 1'b0;
    bus.in_data = 8'h00; bus.in_ena = 1'b0; bus.rd_req = 1'b0;
    do_reset();

    chk("reset miso",      bus.miso,      0);
    chk("reset out_data",  bus.out_data,  0);
    chk("reset have_msg",  bus.have_msg,  0);
    chk("reset len",       bus.len,       0);
    chk("reset tx_full",   bus.tx_full,   0);
    chk("reset frame_err", bus.frame_err, 0);
    chk("reset tx_udf",    bus.tx_udf,    0);
    chk("reset rx_ovf",    bus.rx_ovf,    0);

    for (int v = 0; v < 4; v++) begin
      push_tx(vecs[v].tx_word[15:8]);
      push_tx(vecs[v].tx_word[7:0]);
      u0 = udf_seen; f0 = fe_seen;
      cs_begin();
      send_bits(16, {16'h0, vecs[v].mosi_word}, 6, -1, mi);
      cs_end();
      chk($sformatf("vec%0d miso word", v), mi, {16'h0, vecs[v].exp_miso});
      chk($sformatf("vec%0d len", v), bus.len, 2);
      chk($sformatf("vec%0d have_msg", v), bus.have_msg, 1);
      read_rx(b);
      chk($sformatf("vec%0d rx byte0", v), b, vecs[v].exp_b0);
      read_rx(b);
      chk($sformatf("vec%0d rx byte1", v), b, vecs[v].exp_b1);
      chk($sformatf("vec%0d len after reads", v), bus.len, 0);
      chk($sformatf("vec%0d tx_udf pulses", v), udf_seen - u0, 0);
      chk($sformatf("vec%0d frame_err pulses", v), fe_seen - f0, 0);
      chk($sformatf("vec%0d rx_ovf", v), bus.rx_ovf, 0);
    end

    // Two-word frame with only one word buffered.
    push_tx(8'h11);
    push_tx(8'h22);
    u0 = udf_seen;
    cs_begin();
    send_bits(32, 32'hDEADBEEF, 6, -1, mi);
    cs_end();
    chk("udf miso", mi, 32'h11220000);
    chk("udf pulses", udf_seen - u0, 1);
    chk("udf len", bus.len, 4);
    read_rx(b); chk("udf rx0", b, 8'hDE);
    read_rx(b); chk("udf rx1", b, 8'hAD);
    read_rx(b); chk("udf rx2", b, 8'hBE);
    read_rx(b); chk("udf rx3", b, 8'hEF);

    // Partial frame: 0xC3 followed by three stray bits.
    f0 = fe_seen;
    cs_begin();
    send_bits(11, 32'h61D, 6, -1, mi);
    cs_end();
    chk("partial frame_err pulses", fe_seen - f0, 1);
    chk("partial len", bus.len, 1);
    cs_begin();
    send_bits(8, 32'h5A, 6, -1, mi);
    cs_end();
    chk("partial next len", bus.len, 2);
    chk("partial next frame_err", fe_seen - f0, 1);
    read_rx(b); chk("partial rx0", b, 8'hC3);
    read_rx(b); chk("partial rx1", b, 8'h5A);

    // Reset in the middle of a frame with TX bytes still queued.
    push_tx(8'hAA); push_tx(8'hBB); push_tx(8'hCC); push_tx(8'hDD);
    cs_begin();
    send_bits(5, 32'h16, 6, -1, mi);
    rst = 1'b1;
    tick(1);
    chk("midrst miso",     bus.miso,     0);
    chk("midrst len",      bus.len,      0);
    chk("midrst have_msg", bus.have_msg, 0);
    chk("midrst out_data", bus.out_data, 0);
    chk("midrst tx_full",  bus.tx_full,  0);
    chk("midrst rx_ovf",   bus.rx_ovf,   0);
    rst = 1'b0;
    tick(4);
    send_bits(16, 32'hFFFF, 6, -1, mi);
    tick(8);
    chk("midrst ignored len", bus.len, 0);
    chk("midrst ignored miso", mi, 0);
    cs_end();
    cs_begin();
    send_bits(8, 32'h96, 6, -1, mi);
    cs_end();
    chk("midrst tx emptied", mi, 0);
    chk("midrst new frame len", bus.len, 1);
    read_rx(b); chk("midrst rx", b, 8'h96);

    // Read on empty keeps out_data; read coinciding with a push keeps len.
    read_rx(b);
    chk("empty rd out_data", b, 8'h96);
    chk("empty rd len", bus.len, 0);
    cs_begin();
    send_bits(16, 32'hABCD, 6, 15, mi);
    cs_end();
    chk("push+pop len before", len_pre, 1);
    chk("push+pop len after", len_post, 1);
    chk("push+pop out_data", bus.out_data, 8'hAB);
    read_rx(b); chk("push+pop rx1", b, 8'hCD);
    chk("push+pop len end", bus.len, 0);

    // Fill TX FIFO, overfill, then drain it over one long frame.
    do_reset();
    for (int i = 0; i < 256; i++) push_tx(8'(i));
    chk("tx_full set", bus.tx_full, 1);
    for (int i = 0; i < 4; i++) push_tx(8'hEE);
    chk("tx_full held", bus.tx_full, 1);
    u0 = udf_seen;
    cs_begin();
    for (int w = 0; w < 129; w++) begin
      send_bits(16, 0, 4, -1, mi);
      if (w < 128) chk($sformatf("drain word%0d", w), mi, {16'h0, 8'(2*w), 8'(2*w+1)});
      else         chk("drain word128", mi, 0);
    end
    cs_end();
    chk("drain udf pulses", udf_seen - u0, 1);
    chk("drain tx_full clear", bus.tx_full, 0);

    // RX overflow: 65 words, no reads.
    do_reset();
    cs_begin();
    for (int w = 0; w < 65; w++) send_bits(16, {16'h0, 8'(2*w), 8'(2*w+1)}, 4, -1, mi);
    cs_end();
    chk("ovf len", bus.len, 128);
    chk("ovf rx_ovf", bus.rx_ovf, 1);
    chk("ovf have_msg", bus.have_msg, 1);
    for (int k = 0; k < 128; k++) begin
      read_rx(b);
      chk($sformatf("ovf rx%0d", k), b, 8'(k));
    end
    chk("ovf drained len", bus.len, 0);
    chk("ovf drained have_msg", bus.have_msg, 0);
    chk("ovf sticky", bus.rx_ovf, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
